// File: rtl/vga_draw_req_arbiter.sv
// vga_draw_req_arbiter: round-robin share of the VGA_Drawing AXI4-Lite register slave.
// Each grant latches a 4-word command and writes it as one AW/W/B exchange per word.
//
// state | meaning
// IDLE  | waiting for any req; the only state where a grant is decided
// SEND  | AW and W outstanding for word idx
// RESP  | waiting for BRESP of word idx
// DONE  | ack/err pulse for the granted requester, rr pointer advances

module vga_draw_req_arbiter #(
    parameter int          N_REQ     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*128-1:0] cmd,
    output logic [N_REQ-1:0]     ack,
    output logic                 err,
    output logic                 busy,
    output logic [ADDR_W-1:0]    awaddr,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   grant;
    logic [127:0]    cmd_lat;
    logic [1:0]      idx;
    logic            err_acc;
    logic            aw_done;
    logic            w_done;

    logic            gnt_any;
    logic [GW-1:0]   gnt_idx;
    logic            aw_fin;
    logic            w_fin;
    logic [1:0]      idx_nxt;
    logic [GW-1:0]   rr_nxt;

    function automatic logic [GW-1:0] wrap_idx(input int v);
        int w;
        w = (v >= N_REQ) ? v - N_REQ : v;
        return GW'(w);
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [1:0] i);
        return ADDR_W'(BASE_ADDR) + ADDR_W'({i, 2'b00});
    endfunction

    // First set req at or above rr_ptr, wrapping; rr_ptr is one past the last grant.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_any && req[wrap_idx(int'(rr_ptr) + k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(int'(rr_ptr) + k);
            end
        end
    end

    assign aw_fin  = aw_done | (awvalid & awready);
    assign w_fin   = w_done  | (wvalid  & wready);
    assign idx_nxt = idx + 2'd1;
    assign rr_nxt  = (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;

    assign awprot = 3'b000;
    assign wstrb  = 4'hF;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant   <= '0;
            cmd_lat <= '0;
            idx     <= 2'd0;
            err_acc <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            ack     <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            awaddr  <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        grant   <= gnt_idx;
                        cmd_lat <= cmd[int'(gnt_idx)*128 +: 128];
                        idx     <= 2'd0;
                        err_acc <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        busy    <= 1'b1;
                        awaddr  <= word_addr(2'd0);
                        wdata   <= cmd[int'(gnt_idx)*128 +: 32];
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= RESP;
                    end else begin
                        aw_done <= aw_fin;
                        w_done  <= w_fin;
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        err_acc <= err_acc | (bresp != 2'b00);
                        if (idx == 2'd3) begin
                            ack[grant] <= 1'b1;
                            err        <= err_acc | (bresp != 2'b00);
                            state      <= DONE;
                        end else begin
                            idx     <= idx_nxt;
                            awaddr  <= word_addr(idx_nxt);
                            wdata   <= cmd_lat[int'(idx_nxt)*32 +: 32];
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= SEND;
                        end
                    end
                end
                DONE: begin
                    err    <= 1'b0;
                    busy   <= 1'b0;
                    rr_ptr <= rr_nxt;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_draw_req_arbiter.sv
// Directed bench for vga_draw_req_arbiter (N_REQ=4) with a small AXI4-Lite write slave model
// and a valid/payload stability monitor.

module tb_vga_draw_req_arbiter;

    localparam int N = 4;

    logic           ACLK = 1'b0;
    logic           ARESET = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*128-1:0] cmd = '0;
    logic [N-1:0]   ack;
    logic           err;
    logic           busy;
    logic [31:0]    awaddr;
    logic [2:0]     awprot;
    logic           awvalid;
    logic           awready = 1'b0;
    logic [31:0]    wdata;
    logic [3:0]     wstrb;
    logic           wvalid;
    logic           wready = 1'b0;
    logic [1:0]     bresp = 2'b00;
    logic           bvalid = 1'b0;
    logic           bready;

    int checks = 0;
    int errors = 0;

    // slave model state and configuration
    bit          cfg_rand = 0;
    int          cfg_w_wait = 0;
    int          cfg_err_idx = -1;
    bit          have_aw, have_w, b_pend, b_err;
    int          aw_age, b_cnt;
    logic [31:0] cap_addr, cap_data;
    logic [31:0] mem [4];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    int          aw_hs_cnt = 0;
    int          proto_err = 0;
    bit          p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_awaddr, p_wdata;

    vga_draw_req_arbiter #(
        .N_REQ     (N),
        .BASE_ADDR (32'h0000_0000),
        .ADDR_W    (32)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .req     (req),
        .cmd     (cmd),
        .ack     (ack),
        .err     (err),
        .busy    (busy),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (ARESET) begin
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b0;
            bresp   = 2'b00;
        end else begin
            awready = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cfg_w_wait > 0) wready = have_aw && (aw_age >= cfg_w_wait);
            else                wready = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bvalid = b_pend && (b_cnt == 0);
            bresp  = b_err ? 2'b10 : 2'b00;
        end
    end

    always @(posedge ACLK) begin
        if (ARESET) begin
            have_aw = 0; have_w = 0; b_pend = 0; b_err = 0;
            aw_age = 0; b_cnt = 0; p_awv = 0; p_wv = 0;
        end else begin
            if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) proto_err++;
            if (p_wv && !p_wr && (!wvalid || wdata !== p_wdata)) proto_err++;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata;
            if (awvalid && awready) begin
                if (have_aw) proto_err++;
                have_aw = 1; cap_addr = awaddr; aw_age = 0; aw_hs_cnt++;
            end else if (have_aw) begin
                aw_age++;
            end
            if (wvalid && wready) begin
                if (have_w) proto_err++;
                have_w = 1; cap_data = wdata;
            end
            if (bvalid && bready) b_pend = 0;
            else if (b_pend && b_cnt > 0) b_cnt--;
            if (have_aw && have_w) begin
                log_addr.push_back(cap_addr);
                log_data.push_back(cap_data);
                mem[cap_addr[3:2]] = cap_data;
                b_err = (cfg_err_idx == int'(cap_addr[3:2]));
                b_pend = 1;
                b_cnt = cfg_rand ? $urandom_range(0, 3) : 0;
                have_aw = 0; have_w = 0; aw_age = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] cmd_word(input int i, input int k);
        return cmd[i*128 + k*32 +: 32];
    endfunction

    function automatic logic [31:0] rnd_word(input int i, input int n, input int k);
        return {4'hD, 4'(i), 8'(n), 8'(k), 8'h5A};
    endfunction

    task automatic set_word(input int i, input int k, input logic [31:0] v);
        cmd[i*128 + k*32 +: 32] = v;
    endtask

    task automatic wait_ack(input int limit, output int cyc, output bit timed_out);
        cyc = 0;
        timed_out = 1;
        while (timed_out && cyc < limit) begin
            @(negedge ACLK);
            cyc++;
            if (ack != '0) timed_out = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESET = 1'b1;
        req = '0;
        cfg_rand = 0; cfg_w_wait = 0; cfg_err_idx = -1;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        log_addr.delete();
        log_data.delete();
        aw_hs_cnt = 0;
        proto_err = 0;
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        ARESET = 1'b1;
        req = '0;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({ack, err, busy} !== '0) begin
            errors++; $display("FAIL reset_status: ack/err/busy=%b required 0", {ack, err, busy});
        end
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b000) begin
            errors++; $display("FAIL reset_valids: aw/w/b=%b required 000", {awvalid, wvalid, bready});
        end
        checks++;
        if ({awaddr, wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_payload: awaddr=%0h wdata=%0h required 0", awaddr, wdata);
        end
        checks++;
        if ({awprot, wstrb} !== 7'b000_1111) begin
            errors++; $display("FAIL tied_outputs: awprot=%b wstrb=%b required 000/1111", awprot, wstrb);
        end
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({busy, awvalid} !== 2'b00) begin
            errors++; $display("FAIL idle_no_req: busy/awvalid=%b required 00", {busy, awvalid});
        end
    endtask

    task automatic test_single();
        int c; bit to;
        do_reset();
        for (int k = 0; k < 4; k++) set_word(0, k, 32'(k + 1));
        req = 4'b0001;
        @(negedge ACLK);
        checks++;
        if ({busy, awvalid, wvalid, awaddr, wdata} !== {3'b111, 32'h0, 32'h1}) begin
            errors++; $display("FAIL single_first_aw: b/aw/w=%b awaddr=%0h wdata=%0h required 111/0/1",
                               {busy, awvalid, wvalid}, awaddr, wdata);
        end
        wait_ack(40, c, to);
        checks++;
        if (to || c + 1 != 9) begin
            errors++; $display("FAIL single_ack_cycle: got %0d (timeout=%0d) required 9", c + 1, to);
        end
        checks++;
        if ({ack, err} !== {4'b0001, 1'b0}) begin
            errors++; $display("FAIL single_ack_err: ack=%b err=%b required 0001/0", ack, err);
        end
        req = '0;
        @(negedge ACLK);
        checks++;
        if ({ack, busy} !== 5'b0) begin
            errors++; $display("FAIL single_after_done: ack=%b busy=%b required 0000/0", ack, busy);
        end
        checks++;
        if (log_addr.size() != 4) begin
            errors++; $display("FAIL single_write_count: got %0d required 4", log_addr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (log_addr[k] !== 32'(4 * k) || log_data[k] !== 32'(k + 1) || mem[k] !== 32'(k + 1)) begin
                    errors++; $display("FAIL single_write_%0d: addr=%0h data=%0h mem=%0h required %0h/%0h",
                                       k, log_addr[k], log_data[k], mem[k], 4 * k, k + 1);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int c; bit to;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_word(0, k, 32'hA000_0000 + 32'(k + 1));
            set_word(1, k, 32'hB000_0000 + 32'(k + 1));
        end
        req = 4'b0011;
        wait_ack(40, c, to);
        checks++;
        if (to || c != 9 || ack !== 4'b0001) begin
            errors++; $display("FAIL rr_first: ack=%b cycle=%0d required 0001 at 9", ack, c);
        end
        @(negedge ACLK);
        checks++;
        if ({ack, busy} !== 5'b0) begin
            errors++; $display("FAIL rr_ack_pulse: ack=%b busy=%b required 0000/0", ack, busy);
        end
        @(negedge ACLK);
        checks++;
        if ({busy, awvalid, wdata} !== {2'b11, 32'hB000_0001}) begin
            errors++; $display("FAIL rr_second_grant: busy/aw=%b wdata=%0h required 11/b0000001",
                               {busy, awvalid}, wdata);
        end
        wait_ack(40, c, to);
        checks++;
        if (to || c != 8 || ack !== 4'b0010) begin
            errors++; $display("FAIL rr_second: ack=%b cycle=%0d required 0010 at 8", ack, c);
        end
        req = 4'b0001;
        wait_ack(40, c, to);
        checks++;
        if (to || c != 10 || ack !== 4'b0001) begin
            errors++; $display("FAIL rr_third: ack=%b cycle=%0d required 0001 at 10", ack, c);
        end
        req = '0;
        repeat (4) @(negedge ACLK);
        checks++;
        if ({busy, awvalid} !== 2'b00) begin
            errors++; $display("FAIL rr_quiet: busy/aw=%b required 00", {busy, awvalid});
        end
        checks++;
        if (log_data.size() != 12 || log_data[0] !== 32'hA000_0001 || log_data[4] !== 32'hB000_0001
            || log_data[8] !== 32'hA000_0001 || log_data[7] !== 32'hB000_0004) begin
            errors++; $display("FAIL rr_write_order: count=%0d required 12 ordered A,B,A", log_data.size());
        end
    endtask

    task automatic test_w_stall();
        int c; bit to;
        do_reset();
        cfg_w_wait = 3;
        for (int k = 0; k < 4; k++) set_word(0, k, 32'hC000_0000 + 32'(k + 1));
        req = 4'b0001;
        @(negedge ACLK);
        checks++;
        if ({awvalid, wvalid} !== 2'b11) begin
            errors++; $display("FAIL stall_start: aw/w=%b required 11", {awvalid, wvalid});
        end
        for (int cy = 2; cy <= 5; cy++) begin
            @(negedge ACLK);
            checks++;
            if ({awvalid, wvalid, wdata} !== {2'b01, 32'hC000_0001}) begin
                errors++; $display("FAIL stall_cycle_%0d: aw/w=%b wdata=%0h required 01/c0000001",
                                   cy, {awvalid, wvalid}, wdata);
            end
        end
        @(negedge ACLK);
        checks++;
        if ({wvalid, bready} !== 2'b01) begin
            errors++; $display("FAIL stall_resp: w/bready=%b required 01", {wvalid, bready});
        end
        wait_ack(80, c, to);
        checks++;
        if (to || c != 19 || ack !== 4'b0001) begin
            errors++; $display("FAIL stall_ack: ack=%b cycle=%0d required 0001 at 19", ack, c);
        end
        req = '0;
        checks++;
        if (aw_hs_cnt != 4 || proto_err != 0) begin
            errors++; $display("FAIL stall_aw_count: aw=%0d protocol=%0d required 4/0", aw_hs_cnt, proto_err);
        end
        checks++;
        if (log_data.size() != 4 || log_data[3] !== 32'hC000_0004 || log_addr[3] !== 32'hC) begin
            errors++; $display("FAIL stall_writes: count=%0d required 4 ending c0000004@c", log_data.size());
        end
    endtask

    task automatic test_bresp_err();
        int c; bit to;
        do_reset();
        cfg_err_idx = 1;
        for (int k = 0; k < 4; k++) set_word(0, k, 32'hE000_0000 + 32'(k));
        req = 4'b0001;
        wait_ack(40, c, to);
        checks++;
        if (to || c != 9 || {ack, err} !== 5'b0001_1) begin
            errors++; $display("FAIL berr_ack: ack=%b err=%b cycle=%0d required 0001/1 at 9", ack, err, c);
        end
        req = '0;
        @(negedge ACLK);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL berr_pulse: err=%b required 0", err);
        end
        checks++;
        if (log_addr.size() != 4 || log_addr[2] !== 32'h8 || log_data[3] !== 32'hE000_0003) begin
            errors++; $display("FAIL berr_no_abort: count=%0d required 4 incl. words 2,3", log_addr.size());
        end
        cfg_err_idx = -1;
        set_word(0, 0, 32'h1234_5678);
        req = 4'b0001;
        wait_ack(40, c, to);
        checks++;
        if (to || {ack, err} !== 5'b0001_0) begin
            errors++; $display("FAIL berr_next_clean: ack=%b err=%b required 0001/0", ack, err);
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        int c; bit to;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_word(0, k, 32'h1000_0000 + 32'(k));
            set_word(1, k, 32'h2000_0000 + 32'(k));
        end
        req = 4'b0001;
        wait_ack(40, c, to);
        req = '0;
        @(negedge ACLK);
        req = 4'b0011;
        @(negedge ACLK);
        checks++;
        if ({awvalid, wdata} !== {1'b1, 32'h2000_0000}) begin
            errors++; $display("FAIL rst_pre_grant: aw=%b wdata=%0h required 1/20000000", awvalid, wdata);
        end
        repeat (5) @(negedge ACLK);
        checks++;
        if ({bready, awaddr} !== {1'b1, 32'h8}) begin
            errors++; $display("FAIL rst_in_resp2: bready=%b awaddr=%0h required 1/8", bready, awaddr);
        end
        ARESET = 1'b1;
        #1;
        checks++;
        if ({ack, err, busy, awvalid, wvalid, bready, awaddr, wdata} !== '0) begin
            errors++; $display("FAIL rst_async_clear: flags=%b awaddr=%0h wdata=%0h required 0",
                               {ack, err, busy, awvalid, wvalid, bready}, awaddr, wdata);
        end
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({awvalid, awaddr, wdata} !== {1'b1, 32'h0, 32'h1000_0000}) begin
            errors++; $display("FAIL rst_regrant_rr0: aw=%b awaddr=%0h wdata=%0h required 1/0/10000000",
                               awvalid, awaddr, wdata);
        end
        wait_ack(40, c, to);
        checks++;
        if (to || c != 8 || ack !== 4'b0001) begin
            errors++; $display("FAIL rst_ack0: ack=%b cycle=%0d required 0001 at 8", ack, c);
        end
        req = 4'b0010;
        wait_ack(40, c, to);
        checks++;
        if (to || c != 10 || ack !== 4'b0010) begin
            errors++; $display("FAIL rst_ack1: ack=%b cycle=%0d required 0010 at 10", ack, c);
        end
        req = '0;
    endtask

    task automatic test_random();
        int done_cnt [N];
        int rest [N];
        int since [N];
        int total, cyc, a;
        bit bad;
        do_reset();
        cfg_rand = 1;
        total = 0; cyc = 0; a = 0;
        for (int i = 0; i < N; i++) begin
            done_cnt[i] = 0; rest[i] = 0; since[i] = 0;
            for (int k = 0; k < 4; k++) set_word(i, k, rnd_word(i, 0, k));
        end
        req = '1;
        while (total < 200 && cyc < 40000) begin
            @(negedge ACLK);
            cyc++;
            if (ack != '0) begin
                checks++;
                if (!$onehot(ack) || (ack & ~req) != '0) begin
                    errors++; $display("FAIL rand_ack_onehot: ack=%b req=%b", ack, req);
                end
                for (int i = 0; i < N; i++) if (ack[i]) a = i;
                checks++;
                if (err !== 1'b0) begin
                    errors++; $display("FAIL rand_err: err=%b required 0", err);
                end
                checks++;
                if (since[a] > N - 1) begin
                    errors++; $display("FAIL rand_starvation: req %0d waited %0d grants, limit %0d", a, since[a], N - 1);
                end
                checks++;
                if (aw_hs_cnt != 4) begin
                    errors++; $display("FAIL rand_aw_count: got %0d required 4", aw_hs_cnt);
                end
                bad = (log_data.size() != 4);
                if (!bad)
                    for (int k = 0; k < 4; k++)
                        if (log_addr[k] !== 32'(4 * k) || log_data[k] !== rnd_word(a, done_cnt[a], k)) bad = 1;
                checks++;
                if (bad) begin
                    errors++; $display("FAIL rand_data: req %0d cmd %0d writes=%0d first=%0h required %0h",
                                       a, done_cnt[a], log_data.size(),
                                       (log_data.size() > 0) ? log_data[0] : 32'h0, rnd_word(a, done_cnt[a], 0));
                end
                log_addr.delete();
                log_data.delete();
                aw_hs_cnt = 0;
                for (int j = 0; j < N; j++) if (j != a && req[j]) since[j]++;
                since[a] = 0;
                done_cnt[a]++;
                total++;
                req[a] = 1'b0;
                rest[a] = $urandom_range(0, 3);
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] && done_cnt[i] < 50) begin
                    if (rest[i] == 0) begin
                        for (int k = 0; k < 4; k++) set_word(i, k, rnd_word(i, done_cnt[i], k));
                        req[i] = 1'b1;
                        since[i] = 0;
                    end else begin
                        rest[i]--;
                    end
                end
            end
        end
        checks++;
        if (total != 200) begin
            errors++; $display("FAIL rand_completion: acked %0d commands required 200", total);
        end
        checks++;
        if (proto_err != 0) begin
            errors++; $display("FAIL rand_protocol: %0d violations required 0", proto_err);
        end
        cfg_rand = 0;
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_w_stall();
        test_bresp_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
